// File: rtl/bp_pkg.sv
// Shared types for the branch predictor: counter encoding and FSM states.
package bp_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t SNT = 2'b00;
  localparam ctr_t WNT = 2'b01;
  localparam ctr_t WT  = 2'b10;
  localparam ctr_t ST  = 2'b11;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_PEND = 1'b1
  } state_t;

endpackage

// File: rtl/sat_counter2.sv
// Two-bit saturating counter step: moves toward taken or not-taken.
module sat_counter2
  import bp_pkg::*;
(
  input  logic [1:0] cur,
  input  logic       taken,
  output logic [1:0] nxt
);

  always_comb begin
    nxt = cur;
    unique case (1'b1)
      (taken && cur != ST):   nxt = cur + 2'd1;
      (!taken && cur != SNT): nxt = cur - 2'd1;
      default:                nxt = cur;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal branch predictor with one pending branch in flight.
// Define GSHARE_EN to XOR a global history register into the index.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int PC_W  = 32,
  parameter int IDX_W = 4
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_br,
  input  logic [PC_W-1:0] i_pc,
  input  logic            i_upd,
  input  logic            i_taken,
  output logic            o_pred,
  output logic            o_busy,
  output logic [15:0]     o_miss_cnt
);

  localparam int N = 2 ** IDX_W;

  ctr_t             pht [N];
  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] pend_idx;
  logic             pend_pred;
  logic [15:0]      miss_cnt;
  logic             pred_raw;
  logic             upd_ok;
  ctr_t             ctr_nxt;

  wire unused_pc = ^{i_pc[PC_W-1:IDX_W+2], i_pc[1:0]};

`ifdef GSHARE_EN
  logic [IDX_W-1:0] ghr;

  assign idx = i_pc[IDX_W+1:2] ^ ghr;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)
      ghr <= '0;
    else if (upd_ok)
      ghr <= (ghr << 1) | IDX_W'(i_taken);
  end
`else
  assign idx = i_pc[IDX_W+1:2];
`endif

  // Read is the pre-update value: no bypass from the write port.
  assign pred_raw   = pht[idx][1];
  assign o_pred     = i_rst_n & pred_raw;
  assign o_busy     = i_rst_n & (state == S_PEND);
  assign o_miss_cnt = miss_cnt;
  assign upd_ok     = i_upd && (state == S_PEND);

  sat_counter2 u_ctr (
    .cur   (pht[pend_idx]),
    .taken (i_taken),
    .nxt   (ctr_nxt)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      pend_idx  <= '0;
      pend_pred <= 1'b0;
      miss_cnt  <= '0;
      for (int i = 0; i < N; i++)
        pht[i] <= WNT;
    end else begin
      if (upd_ok) begin
        pht[pend_idx] <= ctr_nxt;
        if (pend_pred != i_taken && miss_cnt != 16'hFFFF)
          miss_cnt <= miss_cnt + 16'd1;
      end
      if (i_br) begin
        pend_idx  <= idx;
        pend_pred <= pred_raw;
      end
      unique case (state)
        S_IDLE: if (i_br) state <= S_PEND;
        S_PEND: if (i_upd && !i_br) state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench: driver queues expected outputs, monitor pops and checks.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        br;
  logic [31:0] pc;
  logic        upd;
  logic        taken;
  logic        probe;
  logic        pred;
  logic        busy;
  logic [15:0] miss_cnt;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic        pred;
    logic        busy;
    logic [15:0] miss;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  branch_predictor #(.PC_W(32), .IDX_W(4)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_br       (br),
    .i_pc       (pc),
    .i_upd      (upd),
    .i_taken    (taken),
    .o_pred     (pred),
    .o_busy     (busy),
    .o_miss_cnt (miss_cnt)
  );

  task automatic cmp(input string tag, input string fld,
                     input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s actual=%0h required=%0h", tag, fld, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (br === 1'b1 || probe === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL underflow actual=0 required=1");
      end else begin
        exp_t e;
        e = q.pop_front();
        cmp(e.tag, "pred", {15'd0, pred}, {15'd0, e.pred});
        cmp(e.tag, "busy", {15'd0, busy}, {15'd0, e.busy});
        cmp(e.tag, "miss", miss_cnt, e.miss);
      end
    end
  end

  task automatic cyc(input logic r, input logic b, input logic [31:0] p,
                     input logic u, input logic t, input logic c,
                     input string tag, input logic ep, input logic eb,
                     input logic [15:0] em);
    exp_t e;
    rst_n = r;
    br    = b;
    pc    = p;
    upd   = u;
    taken = t;
    probe = c;
    if (b || c) begin
      e.tag  = tag;
      e.pred = ep;
      e.busy = eb;
      e.miss = em;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    br    = 1'b0;
    pc    = '0;
    upd   = 1'b0;
    taken = 1'b0;
    probe = 1'b0;
    @(posedge clk);
    #1;
    //  rst br pc        upd tk chk tag            pred busy miss
    cyc(0, 0, 32'h10, 0, 0, 0, "",             0, 0, 0);
    cyc(0, 0, 32'h10, 0, 0, 1, "rst",          0, 0, 0);
    cyc(1, 0, 32'h10, 0, 0, 1, "rst_after",    0, 0, 0);
    cyc(1, 1, 32'h10, 0, 0, 0, "br1",          0, 0, 0);
    cyc(1, 0, 32'h10, 1, 1, 1, "upd1",         0, 1, 0);
    cyc(1, 1, 32'h10, 0, 0, 0, "br2",          1, 0, 1);
    cyc(1, 0, 32'h10, 1, 1, 1, "upd2",         1, 1, 1);
    cyc(1, 1, 32'h10, 0, 0, 0, "br3",          1, 0, 1);
    cyc(1, 0, 32'h10, 1, 1, 1, "upd3",         1, 1, 1);
    cyc(1, 0, 32'h10, 1, 1, 1, "idle_upd_t",   1, 0, 1);
    cyc(1, 0, 32'h10, 1, 0, 0, "",             0, 0, 0);
    cyc(1, 0, 32'h10, 1, 0, 0, "",             0, 0, 0);
    cyc(1, 0, 32'h10, 0, 0, 1, "idle_upd_chk", 1, 0, 1);
    cyc(1, 1, 32'h10, 0, 0, 0, "br4",          1, 0, 1);
    cyc(1, 1, 32'h14, 1, 0, 0, "coin",         0, 1, 1);
    cyc(1, 0, 32'h10, 0, 0, 1, "coin_after",   1, 1, 2);
    cyc(1, 0, 32'h14, 1, 1, 1, "upd_idx5",     0, 1, 2);
    cyc(1, 0, 32'h14, 0, 0, 1, "idx5_chk",     1, 0, 3);
    cyc(1, 1, 32'h20, 0, 0, 0, "ovw_a",        0, 0, 3);
    cyc(1, 1, 32'h24, 0, 0, 0, "ovw_b",        0, 1, 3);
    cyc(1, 0, 32'h24, 1, 1, 1, "ovw_upd",      0, 1, 3);
    cyc(1, 0, 32'h24, 0, 0, 1, "ovw_new",      1, 0, 4);
    cyc(1, 0, 32'h20, 0, 0, 1, "ovw_old",      0, 0, 4);
    cyc(1, 1, 32'h24, 0, 0, 0, "rw_br",        1, 0, 4);
    cyc(1, 1, 32'h24, 1, 0, 0, "rw_same",      1, 1, 4);
    cyc(1, 0, 32'h24, 1, 0, 1, "rw_after",     0, 1, 5);
    cyc(1, 1, 32'h10, 0, 0, 0, "pre_rst_br",   1, 0, 6);
    cyc(0, 0, 32'h10, 0, 0, 1, "mid_rst",      0, 0, 6);
    cyc(1, 0, 32'h10, 1, 1, 1, "post_rst_upd", 0, 0, 0);
    cyc(1, 0, 32'h10, 0, 0, 1, "post_rst_10",  0, 0, 0);
    cyc(1, 0, 32'h24, 0, 0, 1, "post_rst_24",  0, 0, 0);
    cyc(1, 0, 32'h00, 0, 0, 1, "post_rst_00",  0, 0, 0);
    cyc(1, 0, 32'h00, 0, 0, 0, "",             0, 0, 0);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
